// File: rtl/guvm_obi_mem_arbiter_if.sv
// Bundle of the three OBI-style ports the arbiter joins: the instruction-fetch
// master, the data/LSU master and the single shared memory port.
//
// Handshake semantics (req/gnt/rvalid):
//   - A request is accepted in the cycle where req and gnt are both high.
//     While req is high without gnt, the master keeps the request fields
//     stable.
//   - rvalid is a single-cycle pulse that carries one response. Responses
//     return in request order, and rdata is meaningful only while rvalid is
//     high.
//
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the core pins on one side and the memory model on the
// other.
interface guvm_obi_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      instr_req_i;
  logic                      instr_gnt_o;
  logic                      instr_rvalid_o;
  logic [ADDR_WIDTH-1:0]     instr_addr_i;
  logic [DATA_WIDTH-1:0]     instr_rdata_o;

  logic                      data_req_i;
  logic                      data_gnt_o;
  logic                      data_rvalid_o;
  logic                      data_we_i;
  logic [DATA_WIDTH/8-1:0]   data_be_i;
  logic [ADDR_WIDTH-1:0]     data_addr_i;
  logic [DATA_WIDTH-1:0]     data_wdata_i;
  logic [DATA_WIDTH-1:0]     data_rdata_o;

  logic                      mem_req_o;
  logic                      mem_gnt_i;
  logic                      mem_rvalid_i;
  logic                      mem_we_o;
  logic [DATA_WIDTH/8-1:0]   mem_be_o;
  logic [ADDR_WIDTH-1:0]     mem_addr_o;
  logic [DATA_WIDTH-1:0]     mem_wdata_o;
  logic [DATA_WIDTH-1:0]     mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/guvm_obi_mem_arbiter.sv
// Two-master to one-port OBI arbiter.
// - The winner is picked combinationally while the FSM is in ARB.
// - Once a request is presented without a grant, the FSM locks onto that
//   source (HOLD) so the shared request fields stay stable.
// - Each accepted request pushes its source bit (0 = instr, 1 = data) into
//   an in-order ID FIFO. Each mem_rvalid_i pops the FIFO head and is routed
//   to the master that issued the request.
// - An rvalid that arrives while the FIFO is empty sets the sticky err_o.
module guvm_obi_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ARB_MODE        = 0,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1),
  localparam int PW             = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  guvm_obi_mem_arbiter_if.slave        bus,
  output logic [CW-1:0]                outstanding_o,
  output logic                         err_o,
  output logic                         dbg_state_o
);

  typedef enum logic {ST_ARB = 1'b0, ST_HOLD = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic                       lock_q, lock_d;   // locked source while in HOLD
  logic                       rr_q, rr_d;       // 1 = data preferred on conflict
  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PW-1:0]              wr_q, wr_d;
  logic [PW-1:0]              rd_q, rd_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic                       sel;
  logic                       sel_req;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       mem_req;
  logic                       grant;
  logic                       pop;
  logic                       head_src;
  logic [ADDR_WIDTH-1:0]      addr_mux;
  logic [DATA_WIDTH-1:0]      wdata_mux;
  logic [DATA_WIDTH/8-1:0]    be_mux;
  logic                       we_mux;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Pick the selected source: the lock holder in HOLD, otherwise arbitration.
  always_comb begin
    sel = 1'b0;
    if (state_q == ST_HOLD) begin
      sel = lock_q;
    end else if (bus.instr_req_i && bus.data_req_i) begin
      sel = (ARB_MODE == 1) ? 1'b1 : rr_q;
    end else begin
      sel = bus.data_req_i;
    end
  end

  // Shared-port request, grant and the selected master's request fields.
  // When nobody is requesting, the fields drive 0. A full FIFO blocks the
  // request, even if a pop happens in the same cycle.
  always_comb begin
    fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
    fifo_empty = (cnt_q == '0);
    sel_req    = sel ? bus.data_req_i : bus.instr_req_i;
    mem_req    = sel_req && !fifo_full;
    grant      = mem_req && bus.mem_gnt_i;
    addr_mux   = '0;
    wdata_mux  = '0;
    be_mux     = '0;
    we_mux     = 1'b0;
    if (sel_req) begin
      addr_mux  = sel ? bus.data_addr_i  : bus.instr_addr_i;
      wdata_mux = sel ? bus.data_wdata_i : '0;
      be_mux    = sel ? bus.data_be_i    : '1;
      we_mux    = sel ? bus.data_we_i    : 1'b0;
    end
  end

  // FSM next state, lock capture and round-robin pointer update.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    case (state_q)
      ST_ARB: begin
        if (mem_req && !bus.mem_gnt_i) begin
          state_d = ST_HOLD;
          lock_d  = sel;
        end
      end
      ST_HOLD: begin
        // A master that drops req while waiting simply releases the lock.
        if (grant || !sel_req) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
    if (grant && (ARB_MODE == 0)) rr_d = ~sel;
  end

  // ID FIFO push/pop, occupancy and sticky error.
  always_comb begin
    fifo_d   = fifo_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    pop      = bus.mem_rvalid_i && !fifo_empty;
    head_src = fifo_q[rd_q];
    err_d    = err_q || (bus.mem_rvalid_i && fifo_empty);
    if (grant) begin
      fifo_d[wr_q] = sel;
      wr_d         = ptr_inc(wr_q);
    end
    if (pop) rd_d = ptr_inc(rd_q);
    case ({grant, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset drops all tracking of in-flight transactions.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ARB;
      lock_q  <= 1'b0;
      rr_q    <= 1'b0;
      fifo_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      fifo_q  <= fifo_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_req_o      = mem_req;
  assign bus.mem_addr_o     = addr_mux;
  assign bus.mem_wdata_o    = wdata_mux;
  assign bus.mem_be_o       = be_mux;
  assign bus.mem_we_o       = we_mux;
  assign bus.instr_gnt_o    = grant && !sel;
  assign bus.data_gnt_o     = grant && sel;
  assign bus.instr_rvalid_o = pop && !head_src;
  assign bus.data_rvalid_o  = pop && head_src;
  assign bus.instr_rdata_o  = bus.mem_rdata_i;
  assign bus.data_rdata_o   = bus.mem_rdata_i;
  assign outstanding_o      = cnt_q;
  assign err_o              = err_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_guvm_obi_mem_arbiter.sv
// Directed bench for guvm_obi_mem_arbiter.
// dut0 runs round-robin arbitration (ARB_MODE=0) and dut1 runs fixed priority
// (ARB_MODE=1). Both receive identical stimulus. dut1 is checked wherever the
// two modes must differ, and at a few common points.
module tb_guvm_obi_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [CW-1:0] out0, out1;
  logic err0, err1, dbg0, dbg1;
  int checks = 0;
  int errors = 0;

  guvm_obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc0 ();
  guvm_obi_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc1 ();

  assign ifc1.instr_req_i  = ifc0.instr_req_i;
  assign ifc1.instr_addr_i = ifc0.instr_addr_i;
  assign ifc1.data_req_i   = ifc0.data_req_i;
  assign ifc1.data_we_i    = ifc0.data_we_i;
  assign ifc1.data_be_i    = ifc0.data_be_i;
  assign ifc1.data_addr_i  = ifc0.data_addr_i;
  assign ifc1.data_wdata_i = ifc0.data_wdata_i;
  assign ifc1.mem_gnt_i    = ifc0.mem_gnt_i;
  assign ifc1.mem_rvalid_i = ifc0.mem_rvalid_i;
  assign ifc1.mem_rdata_i  = ifc0.mem_rdata_i;

  guvm_obi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2), .ARB_MODE(0)) dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(ifc0.slave),
    .outstanding_o(out0), .err_o(err0), .dbg_state_o(dbg0));

  guvm_obi_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2), .ARB_MODE(1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(ifc1.slave),
    .outstanding_o(out1), .err_o(err1), .dbg_state_o(dbg1));

  // Clock and reset
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    ifc0.instr_req_i  = 1'b0;
    ifc0.instr_addr_i = '0;
    ifc0.data_req_i   = 1'b0;
    ifc0.data_we_i    = 1'b0;
    ifc0.data_be_i    = '0;
    ifc0.data_addr_i  = '0;
    ifc0.data_wdata_i = '0;
    ifc0.mem_gnt_i    = 1'b0;
    ifc0.mem_rvalid_i = 1'b0;
    ifc0.mem_rdata_i  = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    do_reset();

    // Reset state
    settle();
    chk("rst_mem_req", ifc0.mem_req_o, 0);
    chk("rst_instr_gnt", ifc0.instr_gnt_o, 0);
    chk("rst_data_gnt", ifc0.data_gnt_o, 0);
    chk("rst_mem_be", ifc0.mem_be_o, 0);
    chk("rst_mem_addr", ifc0.mem_addr_o, 0);
    chk("rst_outstanding", out0, 0);
    chk("rst_err", err0, 0);
    chk("rst_state", dbg0, 0);
    tick();

    // 1: single instr fetch, zero-latency grant, response next cycle
    ifc0.instr_req_i = 1'b1; ifc0.instr_addr_i = 32'h0000_000A; ifc0.mem_gnt_i = 1'b1;
    settle();
    chk("t1_instr_gnt", ifc0.instr_gnt_o, 1);
    chk("t1_data_gnt", ifc0.data_gnt_o, 0);
    chk("t1_mem_req", ifc0.mem_req_o, 1);
    chk("t1_mem_addr", ifc0.mem_addr_o, 32'h0000_000A);
    chk("t1_mem_be", ifc0.mem_be_o, 4'hF);
    chk("t1_mem_we", ifc0.mem_we_o, 0);
    tick();
    ifc0.instr_req_i = 1'b0; ifc0.mem_gnt_i = 1'b0;
    ifc0.mem_rvalid_i = 1'b1; ifc0.mem_rdata_i = 32'h0000_0013;
    settle();
    chk("t1_outstanding_1", out0, 1);
    chk("t1_instr_rvalid", ifc0.instr_rvalid_o, 1);
    chk("t1_data_rvalid", ifc0.data_rvalid_o, 0);
    chk("t1_instr_rdata", ifc0.instr_rdata_o, 32'h0000_0013);
    tick();
    ifc0.mem_rvalid_i = 1'b0;
    settle();
    chk("t1_outstanding_0", out0, 0);

    // 2: both masters request every cycle; RR alternates, fixed priority picks data
    do_reset();
    ifc0.instr_req_i = 1'b1; ifc0.instr_addr_i = 32'h20;
    ifc0.data_req_i = 1'b1; ifc0.data_addr_i = 32'h40; ifc0.data_be_i = 4'hF;
    ifc0.mem_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ifc0.mem_rvalid_i = (k > 0);
      ifc0.mem_rdata_i = 32'(k);
      settle();
      chk("t2_rr_instr_gnt", ifc0.instr_gnt_o, (k % 2 == 0));
      chk("t2_rr_data_gnt", ifc0.data_gnt_o, (k % 2 == 1));
      chk("t2_rr_mem_addr", ifc0.mem_addr_o, (k % 2 == 0) ? 32'h20 : 32'h40);
      chk("t2_fp_data_gnt", ifc1.data_gnt_o, 1);
      chk("t2_fp_instr_gnt", ifc1.instr_gnt_o, 0);
      if (k > 0) begin
        chk("t2_rr_instr_rvalid", ifc0.instr_rvalid_o, (k % 2 == 1));
        chk("t2_rr_data_rvalid", ifc0.data_rvalid_o, (k % 2 == 0));
        chk("t2_fp_data_rvalid", ifc1.data_rvalid_o, 1);
        chk("t2_rr_outstanding", out0, 1);
      end
      tick();
    end
    idle();
    ifc0.mem_rvalid_i = 1'b1;
    settle();
    chk("t2_rr_drain_data_rvalid", ifc0.data_rvalid_o, 1);
    chk("t2_fp_drain_data_rvalid", ifc1.data_rvalid_o, 1);
    tick();
    idle();
    settle();
    chk("t2_rr_outstanding_0", out0, 0);
    chk("t2_fp_outstanding_0", out1, 0);
    chk("t2_rr_err", err0, 0);
    chk("t2_fp_err", err1, 0);

    // 3: data write stalled 3 cycles, instr arrives meanwhile, fields held
    ifc0.data_req_i = 1'b1; ifc0.data_we_i = 1'b1; ifc0.data_addr_i = 32'h100;
    ifc0.data_be_i = 4'hF; ifc0.data_wdata_i = 32'hDEAD_BEEF; ifc0.mem_gnt_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        ifc0.instr_req_i = 1'b1; ifc0.instr_addr_i = 32'h80;
      end
      settle();
      chk("t3_mem_req", ifc0.mem_req_o, 1);
      chk("t3_mem_addr", ifc0.mem_addr_o, 32'h100);
      chk("t3_mem_we", ifc0.mem_we_o, 1);
      chk("t3_mem_wdata", ifc0.mem_wdata_o, 32'hDEAD_BEEF);
      chk("t3_mem_be", ifc0.mem_be_o, 4'hF);
      chk("t3_data_gnt", ifc0.data_gnt_o, 0);
      chk("t3_instr_gnt", ifc0.instr_gnt_o, 0);
      chk("t3_state", dbg0, (c != 0));
      chk("t3_fp_mem_addr", ifc1.mem_addr_o, 32'h100);
      tick();
    end
    ifc0.mem_gnt_i = 1'b1;
    settle();
    chk("t3_c4_data_gnt", ifc0.data_gnt_o, 1);
    chk("t3_c4_instr_gnt", ifc0.instr_gnt_o, 0);
    chk("t3_c4_mem_addr", ifc0.mem_addr_o, 32'h100);
    tick();
    ifc0.data_req_i = 1'b0; ifc0.data_we_i = 1'b0;
    ifc0.mem_rvalid_i = 1'b1; ifc0.mem_rdata_i = 32'h77;
    settle();
    chk("t3_c5_state", dbg0, 0);
    chk("t3_c5_instr_gnt", ifc0.instr_gnt_o, 1);
    chk("t3_c5_mem_addr", ifc0.mem_addr_o, 32'h80);
    chk("t3_c5_mem_we", ifc0.mem_we_o, 0);
    chk("t3_c5_mem_wdata", ifc0.mem_wdata_o, 0);
    chk("t3_c5_data_rvalid", ifc0.data_rvalid_o, 1);
    chk("t3_c5_data_rdata", ifc0.data_rdata_o, 32'h77);
    tick();
    ifc0.instr_req_i = 1'b0;
    settle();
    chk("t3_c6_instr_rvalid", ifc0.instr_rvalid_o, 1);
    tick();
    idle();
    settle();
    chk("t3_outstanding_0", out0, 0);

    // 4: FIFO full blocks a third request; responses return in issue order
    ifc0.instr_req_i = 1'b1; ifc0.instr_addr_i = 32'h200; ifc0.mem_gnt_i = 1'b1;
    settle();
    chk("t4_instr_gnt", ifc0.instr_gnt_o, 1);
    tick();
    ifc0.instr_req_i = 1'b0;
    ifc0.data_req_i = 1'b1; ifc0.data_addr_i = 32'h300; ifc0.data_be_i = 4'h3;
    settle();
    chk("t4_data_gnt", ifc0.data_gnt_o, 1);
    chk("t4_mem_be", ifc0.mem_be_o, 4'h3);
    chk("t4_outstanding_1", out0, 1);
    tick();
    ifc0.data_req_i = 1'b0; ifc0.instr_req_i = 1'b1; ifc0.instr_addr_i = 32'h204;
    settle();
    chk("t4_full_outstanding", out0, 2);
    chk("t4_full_mem_req", ifc0.mem_req_o, 0);
    chk("t4_full_instr_gnt", ifc0.instr_gnt_o, 0);
    chk("t4_full_data_gnt", ifc0.data_gnt_o, 0);
    tick();
    ifc0.mem_rvalid_i = 1'b1; ifc0.mem_rdata_i = 32'h55;
    settle();
    chk("t4_pop1_instr_rvalid", ifc0.instr_rvalid_o, 1);
    chk("t4_pop1_data_rvalid", ifc0.data_rvalid_o, 0);
    chk("t4_pop1_instr_rdata", ifc0.instr_rdata_o, 32'h55);
    chk("t4_nobypass_mem_req", ifc0.mem_req_o, 0);
    chk("t4_nobypass_instr_gnt", ifc0.instr_gnt_o, 0);
    tick();
    ifc0.mem_rdata_i = 32'h66;
    settle();
    chk("t4_after_outstanding", out0, 1);
    chk("t4_after_mem_req", ifc0.mem_req_o, 1);
    chk("t4_after_instr_gnt", ifc0.instr_gnt_o, 1);
    chk("t4_pop2_data_rvalid", ifc0.data_rvalid_o, 1);
    chk("t4_pop2_data_rdata", ifc0.data_rdata_o, 32'h66);
    tick();
    ifc0.instr_req_i = 1'b0;
    settle();
    chk("t4_pop3_outstanding", out0, 1);
    chk("t4_pop3_instr_rvalid", ifc0.instr_rvalid_o, 1);
    tick();
    idle();
    settle();
    chk("t4_outstanding_0", out0, 0);

    // 5: push and pop together at occupancy 1 across pointer wrap
    ifc0.instr_req_i = 1'b1; ifc0.instr_addr_i = 32'h500; ifc0.mem_gnt_i = 1'b1;
    settle();
    tick();
    for (int k = 0; k < 10; k++) begin
      ifc0.instr_req_i = (k % 2 == 1);
      ifc0.data_req_i = (k % 2 == 0);
      ifc0.instr_addr_i = 32'h600 + 32'(k);
      ifc0.data_addr_i = 32'h700 + 32'(k);
      ifc0.mem_rvalid_i = 1'b1;
      ifc0.mem_rdata_i = 32'h1000 + 32'(k);
      settle();
      chk("t5_outstanding", out0, 1);
      chk("t5_instr_rvalid", ifc0.instr_rvalid_o, (k % 2 == 0));
      chk("t5_data_rvalid", ifc0.data_rvalid_o, (k % 2 == 1));
      chk("t5_instr_gnt", ifc0.instr_gnt_o, (k % 2 == 1));
      chk("t5_data_gnt", ifc0.data_gnt_o, (k % 2 == 0));
      chk("t5_rdata", ifc0.data_rdata_o, 32'h1000 + 32'(k));
      tick();
    end
    idle();
    ifc0.mem_rvalid_i = 1'b1;
    settle();
    chk("t5_drain_instr_rvalid", ifc0.instr_rvalid_o, 1);
    tick();
    idle();
    settle();
    chk("t5_outstanding_0", out0, 0);
    chk("t5_err_clear", err0, 0);
    chk("t5_fp_err_clear", err1, 0);

    // 6: rvalid with empty FIFO sets sticky error; async reset clears it
    ifc0.mem_rvalid_i = 1'b1; ifc0.mem_rdata_i = 32'hBAD;
    settle();
    chk("t6_spur_instr_rvalid", ifc0.instr_rvalid_o, 0);
    chk("t6_spur_data_rvalid", ifc0.data_rvalid_o, 0);
    chk("t6_err_before_edge", err0, 0);
    tick();
    ifc0.mem_rvalid_i = 1'b0;
    settle();
    chk("t6_err_set", err0, 1);
    chk("t6_fp_err_set", err1, 1);
    tick();
    ifc0.instr_req_i = 1'b1; ifc0.instr_addr_i = 32'h400; ifc0.mem_gnt_i = 1'b1;
    settle();
    chk("t6_err_sticky", err0, 1);
    chk("t6_instr_gnt", ifc0.instr_gnt_o, 1);
    tick();
    ifc0.instr_req_i = 1'b0; ifc0.mem_gnt_i = 1'b0;
    settle();
    chk("t6_outstanding_1", out0, 1);
    rst_ni = 1'b0;
    #1;
    chk("t6_async_err", err0, 0);
    chk("t6_async_outstanding", out0, 0);
    chk("t6_async_fp_err", err1, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    ifc0.mem_rvalid_i = 1'b1; ifc0.mem_rdata_i = 32'h13;
    settle();
    chk("t6_stale_instr_rvalid", ifc0.instr_rvalid_o, 0);
    chk("t6_stale_err_pre", err0, 0);
    tick();
    ifc0.mem_rvalid_i = 1'b0;
    settle();
    chk("t6_stale_err", err0, 1);
    chk("t6_stale_outstanding", out0, 0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
